// File: rtl/octree_sram_arbiter_if.sv
// Searcher/updater request ports and the single-port octree node SRAM port,
// bundled for the per-access arbiter.
interface octree_sram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
);
    logic              s_req, s_we, s_lock, s_gnt, s_rvalid;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              u_req, u_we, u_lock, u_gnt, u_rvalid;
    logic [ADDR_W-1:0] u_addr;
    logic [DATA_W-1:0] u_wdata;
    logic [DATA_W-1:0] rdata;
    logic              mem_cs, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        mem_owner;
    logic              starve_flag;

    modport slave (
        input  s_req, s_we, s_addr, s_wdata, s_lock,
        input  u_req, u_we, u_addr, u_wdata, u_lock,
        input  mem_rdata,
        output s_gnt, s_rvalid, u_gnt, u_rvalid, rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata, mem_owner, starve_flag
    );

    modport master (
        output s_req, s_we, s_addr, s_wdata, s_lock,
        output u_req, u_we, u_addr, u_wdata, u_lock,
        output mem_rdata,
        input  s_gnt, s_rvalid, u_gnt, u_rvalid, rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata, mem_owner, starve_flag
    );
endinterface

// File: rtl/octree_sram_arbiter.sv
// Per-access arbiter for the octree node SRAM: searcher first, updater
// protected by a starvation counter, either side may lock the port for RMW.
module octree_sram_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    octree_sram_arbiter_if.slave bus
);
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_S    = 2'd1;
    localparam logic [1:0] OWN_U    = 2'd2;
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef struct packed {
        logic              cs;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    logic [1:0] lock_owner, lock_next;
    logic [3:0] starve_cnt;
    logic       starved, s_win, u_win;
    cmd_t       cmd;

    assign starved = (starve_cnt == WAIT_MAX);

    // A held lock beats the starvation guard; an idle lock holder blocks both.
    always_comb begin
        s_win = 1'b0;
        u_win = 1'b0;
        if (lock_owner == OWN_S)         s_win = bus.s_req;
        else if (lock_owner == OWN_U)    u_win = bus.u_req;
        else if (starved && bus.u_req)   u_win = 1'b1;
        else if (bus.s_req)              s_win = 1'b1;
        else                             u_win = bus.u_req;
    end

    always_comb begin
        cmd = '0;
        if (s_win)      cmd = '{cs: 1'b1, we: bus.s_we, addr: bus.s_addr, wdata: bus.s_wdata};
        else if (u_win) cmd = '{cs: 1'b1, we: bus.u_we, addr: bus.u_addr, wdata: bus.u_wdata};
    end

    assign bus.s_gnt       = s_win;
    assign bus.u_gnt       = u_win;
    assign bus.mem_cs      = cmd.cs;
    assign bus.mem_we      = cmd.we;
    assign bus.mem_addr    = cmd.addr;
    assign bus.mem_wdata   = cmd.wdata;
    assign bus.rdata       = bus.mem_rdata;
    assign bus.starve_flag = starved;

    // Holder keeps the lock only while it keeps requesting with lock set;
    // a granted access with lock clear is the last locked one.
    always_comb begin
        lock_next = lock_owner;
        case (lock_owner)
            OWN_NONE: begin
                if (s_win && bus.s_lock)      lock_next = OWN_S;
                else if (u_win && bus.u_lock) lock_next = OWN_U;
            end
            OWN_S:   if (!bus.s_req || !bus.s_lock) lock_next = OWN_NONE;
            OWN_U:   if (!bus.u_req || !bus.u_lock) lock_next = OWN_NONE;
            default: lock_next = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_owner    <= OWN_NONE;
            starve_cnt    <= '0;
            bus.s_rvalid  <= 1'b0;
            bus.u_rvalid  <= 1'b0;
            bus.mem_owner <= OWN_NONE;
        end else begin
            lock_owner    <= lock_next;
            bus.s_rvalid  <= s_win & ~bus.s_we;
            bus.u_rvalid  <= u_win & ~bus.u_we;
            bus.mem_owner <= {u_win, s_win};
            if (!bus.u_req || u_win) starve_cnt <= '0;
            else if (!starved)       starve_cnt <= starve_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_octree_sram_arbiter.sv
// Randomized and directed bench for octree_sram_arbiter against a
// transaction-level reference model and a behavioural SRAM.
module tb_octree_sram_arbiter;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 4;
    localparam int DEPTH    = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    octree_sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    octree_sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return 64'hA5A5_0000_0000_0000 ^ (64'(a) * 64'h0000_0001_9E37_79B9);
    endfunction

    // Behavioural single-port SRAM, 1-cycle read latency
    logic [DATA_W-1:0] sram [DEPTH];
    bit                sram_wr [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_cs) begin
            if (bus.mem_we) begin
                sram[bus.mem_addr]    <= bus.mem_wdata;
                sram_wr[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= sram_wr[bus.mem_addr] ? sram[bus.mem_addr] : init_val(bus.mem_addr);
            end
        end
    end

    // Reference model: who holds the port, how long the updater has waited,
    // what read is in flight, and the expected memory image.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_wr  [DEPTH];
    int                m_hold, m_wait, m_owner, m_win;
    bit                m_pend_s, m_pend_u;
    logic [DATA_W-1:0] m_pend_data;
    logic              e_cs, e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    task automatic model_reset();
        m_hold = 0; m_wait = 0; m_owner = 0; m_win = 0;
        m_pend_s = 0; m_pend_u = 0;
    endtask

    task automatic model_eval();
        if (m_hold == 1)                          m_win = bus.s_req ? 1 : 0;
        else if (m_hold == 2)                     m_win = bus.u_req ? 2 : 0;
        else if (bus.u_req && m_wait >= MAX_WAIT) m_win = 2;
        else if (bus.s_req)                       m_win = 1;
        else if (bus.u_req)                       m_win = 2;
        else                                      m_win = 0;
        e_cs = (m_win != 0);
        e_we = (m_win == 1) ? bus.s_we : (m_win == 2) ? bus.u_we : 1'b0;
        e_addr = (m_win == 1) ? bus.s_addr : (m_win == 2) ? bus.u_addr : '0;
        e_wdata = (m_win == 1) ? bus.s_wdata : (m_win == 2) ? bus.u_wdata : '0;
    endtask

    task automatic model_adv();
        m_pend_s = (m_win == 1) && !bus.s_we;
        m_pend_u = (m_win == 2) && !bus.u_we;
        if (e_cs) begin
            if (e_we) begin ref_mem[e_addr] = e_wdata; ref_wr[e_addr] = 1'b1; end
            else m_pend_data = ref_rd(e_addr);
        end
        if (m_hold == 0) begin
            if (m_win == 1 && bus.s_lock)      m_hold = 1;
            else if (m_win == 2 && bus.u_lock) m_hold = 2;
        end else if (m_hold == 1) begin
            if (!bus.s_req || !bus.s_lock) m_hold = 0;
        end else if (!bus.u_req || !bus.u_lock) m_hold = 0;
        if (bus.u_req && m_win != 2) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
        else                         m_wait = 0;
        m_owner = m_win;
    endtask

    task automatic settle(); model_eval(); #2; endtask
    task automatic step(); model_eval(); model_adv(); @(posedge clk); #1; endtask

    task automatic drive_idle();
        bus.s_req = 0; bus.s_we = 0; bus.s_addr = '0; bus.s_wdata = '0; bus.s_lock = 0;
        bus.u_req = 0; bus.u_we = 0; bus.u_addr = '0; bus.u_wdata = '0; bus.u_lock = 0;
    endtask

    task automatic set_s(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic lk);
        bus.s_req = 1; bus.s_we = we; bus.s_addr = a; bus.s_wdata = d; bus.s_lock = lk;
    endtask

    task automatic set_u(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic lk);
        bus.u_req = 1; bus.u_we = we; bus.u_addr = a; bus.u_wdata = d; bus.u_lock = lk;
    endtask

    task automatic test_reset();
        drive_idle();
        model_reset();
        #3;
        checks++; if (bus.s_gnt !== 1'b0 || bus.u_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", bus.s_gnt, bus.u_gnt); end
        checks++; if (bus.mem_cs !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b want 0", bus.mem_cs); end
        checks++; if (bus.mem_owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d want 0", bus.mem_owner); end
        checks++; if (bus.s_rvalid !== 1'b0 || bus.u_rvalid !== 1'b0 || bus.starve_flag !== 1'b0) begin
            errors++; $display("FAIL reset_regs: got rv %b%b flag %b want 000", bus.s_rvalid, bus.u_rvalid, bus.starve_flag); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_search_only();
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            if (i < 4) set_s(1'b0, ADDR_W'(32'h010 + i), '0, 1'b0);
            settle();
            checks++; if (bus.s_gnt !== (i < 4)) begin errors++; $display("FAIL search_gnt[%0d]: got %b want %b", i, bus.s_gnt, (i < 4)); end
            if (i < 4) begin
                checks++; if (bus.mem_addr !== e_addr) begin errors++; $display("FAIL search_addr[%0d]: got %h want %h", i, bus.mem_addr, e_addr); end
            end
            checks++; if (bus.s_rvalid !== (i >= 1 && i <= 4)) begin errors++; $display("FAIL search_rvalid[%0d]: got %b want %b", i, bus.s_rvalid, (i >= 1 && i <= 4)); end
            if (i >= 1 && i <= 4) begin
                checks++; if (bus.rdata !== m_pend_data) begin errors++; $display("FAIL search_rdata[%0d]: got %h want %h", i, bus.rdata, m_pend_data); end
                checks++; if (bus.mem_owner !== 2'd1) begin errors++; $display("FAIL search_owner[%0d]: got %0d want 1", i, bus.mem_owner); end
            end
            step();
        end
    endtask

    task automatic test_contention();
        drive_idle();
        set_u(1'b0, 10'h055, '0, 1'b0);
        for (int k = 0; k < 15; k++) begin
            set_s(1'b0, ADDR_W'($urandom_range(0, 63)), '0, 1'b0);
            settle();
            checks++; if (bus.u_gnt !== (k % 5 == 4) || bus.s_gnt !== (k % 5 != 4)) begin
                errors++; $display("FAIL contend_pattern[%0d]: got s%b u%b want u%b", k, bus.s_gnt, bus.u_gnt, (k % 5 == 4)); end
            checks++; if (bus.starve_flag !== (k % 5 == 4)) begin errors++; $display("FAIL contend_flag[%0d]: got %b want %b", k, bus.starve_flag, (k % 5 == 4)); end
            if (k > 0 && m_pend_u) begin
                checks++; if (bus.u_rvalid !== 1'b1 || bus.rdata !== m_pend_data) begin
                    errors++; $display("FAIL contend_urd[%0d]: got %b %h want 1 %h", k, bus.u_rvalid, bus.rdata, m_pend_data); end
            end
            step();
        end
    endtask

    task automatic test_rmw_lock();
        bit got = 0;
        drive_idle();
        set_s(1'b0, 10'h041, '0, 1'b0);
        set_u(1'b0, 10'h020, '0, 1'b1);
        for (int k = 0; k < 8 && !got; k++) begin
            settle();
            checks++; if (bus.u_gnt !== (m_win == 2) || bus.s_gnt !== (m_win == 1)) begin
                errors++; $display("FAIL rmw_wait_gnt[%0d]: got s%b u%b want s%b u%b", k, bus.s_gnt, bus.u_gnt, m_win == 1, m_win == 2); end
            got = (m_win == 2);
            step();
        end
        checks++; if (!got) begin errors++; $display("FAIL rmw_first_grant: got none want updater within 8 cycles"); end
        set_u(1'b1, 10'h020, 64'hDEAD, 1'b0);
        settle();
        checks++; if (bus.u_gnt !== 1'b1 || bus.s_gnt !== 1'b0) begin errors++; $display("FAIL rmw_write_gnt: got s%b u%b want s0 u1", bus.s_gnt, bus.u_gnt); end
        checks++; if (bus.u_rvalid !== 1'b1 || bus.rdata !== init_val(10'h020)) begin
            errors++; $display("FAIL rmw_read_data: got %b %h want 1 %h", bus.u_rvalid, bus.rdata, init_val(10'h020)); end
        step();
        bus.u_req = 0;
        set_s(1'b0, 10'h020, '0, 1'b0);
        settle();
        checks++; if (bus.s_gnt !== 1'b1) begin errors++; $display("FAIL rmw_s_after: got %b want 1", bus.s_gnt); end
        step();
        drive_idle();
        settle();
        checks++; if (bus.s_rvalid !== 1'b1 || bus.rdata !== 64'hDEAD) begin errors++; $display("FAIL rmw_mem: got %b %h want 1 dead", bus.s_rvalid, bus.rdata); end
        step();
    endtask

    task automatic test_lock_drop();
        drive_idle();
        set_s(1'b0, 10'h030, '0, 1'b1);
        set_u(1'b0, 10'h031, '0, 1'b0);
        settle();
        checks++; if (bus.s_gnt !== 1'b1 || bus.u_gnt !== 1'b0) begin errors++; $display("FAIL drop_lock_gnt: got s%b u%b want s1 u0", bus.s_gnt, bus.u_gnt); end
        step();
        bus.s_req = 0;
        settle();
        checks++; if (bus.u_gnt !== 1'b0 || bus.s_gnt !== 1'b0) begin errors++; $display("FAIL drop_release_cycle: got s%b u%b want s0 u0", bus.s_gnt, bus.u_gnt); end
        checks++; if (bus.s_rvalid !== 1'b1 || bus.rdata !== m_pend_data) begin errors++; $display("FAIL drop_rdata: got %b %h want 1 %h", bus.s_rvalid, bus.rdata, m_pend_data); end
        step();
        settle();
        checks++; if (bus.u_gnt !== 1'b1) begin errors++; $display("FAIL drop_u_next: got %b want 1", bus.u_gnt); end
        step();
        drive_idle();
        step();
    endtask

    task automatic test_starve_lock();
        drive_idle();
        set_u(1'b0, 10'h077, '0, 1'b0);
        for (int k = 0; k < 11; k++) begin
            set_s(1'b0, ADDR_W'(32'h100 + k), '0, (k >= 3 && k < 9));
            settle();
            if (k >= 4 && k <= 9) begin
                checks++; if (bus.u_gnt !== 1'b0 || bus.s_gnt !== 1'b1 || bus.starve_flag !== 1'b1) begin
                    errors++; $display("FAIL starve_locked[%0d]: got s%b u%b flag %b want s1 u0 flag1", k, bus.s_gnt, bus.u_gnt, bus.starve_flag); end
            end else if (k == 10) begin
                checks++; if (bus.u_gnt !== 1'b1 || bus.s_gnt !== 1'b0) begin errors++; $display("FAIL starve_after_release: got s%b u%b want s0 u1", bus.s_gnt, bus.u_gnt); end
            end else begin
                checks++; if (bus.s_gnt !== 1'b1 || bus.u_gnt !== 1'b0) begin errors++; $display("FAIL starve_build[%0d]: got s%b u%b want s1 u0", k, bus.s_gnt, bus.u_gnt); end
            end
            step();
        end
        drive_idle();
        step();
    endtask

    task automatic test_random();
        drive_idle();
        for (int k = 0; k < 300; k++) begin
            if (m_owner == 1 || !bus.s_req) begin
                if ($urandom_range(0, 9) < 7)
                    set_s(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom}, ($urandom_range(0, 3) == 0));
                else bus.s_req = 0;
            end
            if (m_owner == 2 || !bus.u_req) begin
                if ($urandom_range(0, 9) < 6)
                    set_u(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), {$urandom, $urandom}, ($urandom_range(0, 2) == 0));
                else bus.u_req = 0;
            end
            settle();
            checks++; if (bus.s_gnt !== (m_win == 1) || bus.u_gnt !== (m_win == 2) || bus.mem_cs !== e_cs) begin
                errors++; $display("FAIL rand_gnt[%0d]: got s%b u%b cs%b want winner %0d", k, bus.s_gnt, bus.u_gnt, bus.mem_cs, m_win); end
            checks++; if (bus.mem_we !== e_we || bus.mem_addr !== e_addr || bus.mem_wdata !== e_wdata) begin
                errors++; $display("FAIL rand_cmd[%0d]: got %b %h %h want %b %h %h", k, bus.mem_we, bus.mem_addr, bus.mem_wdata, e_we, e_addr, e_wdata); end
            checks++; if (bus.s_rvalid !== m_pend_s || bus.u_rvalid !== m_pend_u || bus.mem_owner !== 2'(m_owner)) begin
                errors++; $display("FAIL rand_regs[%0d]: got rv %b%b own %0d want %b%b %0d", k, bus.s_rvalid, bus.u_rvalid, bus.mem_owner, m_pend_s, m_pend_u, m_owner); end
            checks++; if (bus.starve_flag !== (m_wait == MAX_WAIT)) begin errors++; $display("FAIL rand_flag[%0d]: got %b want %b", k, bus.starve_flag, m_wait == MAX_WAIT); end
            if (m_pend_s || m_pend_u) begin
                checks++; if (bus.rdata !== m_pend_data) begin errors++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, bus.rdata, m_pend_data); end
            end
            step();
        end
        drive_idle();
        step();
    endtask

    task automatic test_reset_mid_read();
        bit got = 0;
        drive_idle();
        set_s(1'b0, 10'h0A0, '0, 1'b0);
        set_u(1'b0, 10'h0B0, '0, 1'b1);
        for (int k = 0; k < 8 && !got; k++) begin
            settle();
            got = (m_win == 2);
            checks++; if (bus.u_gnt !== got) begin errors++; $display("FAIL rst_pre_gnt[%0d]: got %b want %b", k, bus.u_gnt, got); end
            step();
        end
        checks++; if (!got) begin errors++; $display("FAIL rst_pre_grant: got none want updater within 8 cycles"); end
        #1;
        checks++; if (bus.u_rvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_rvalid: got %b want 1", bus.u_rvalid); end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.u_rvalid !== 1'b0 || bus.mem_owner !== 2'd0 || bus.starve_flag !== 1'b0) begin
            errors++; $display("FAIL rst_mid: got rv %b own %0d flag %b want 0 0 0", bus.u_rvalid, bus.mem_owner, bus.starve_flag); end
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_s(1'b0, 10'h0A0, '0, 1'b0);
        set_u(1'b0, 10'h0B0, '0, 1'b1);
        settle();
        checks++; if (bus.s_gnt !== 1'b1 || bus.u_gnt !== 1'b0) begin errors++; $display("FAIL rst_post_gnt: got s%b u%b want s1 u0", bus.s_gnt, bus.u_gnt); end
        step();
        drive_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_search_only();
        test_contention();
        test_rmw_lock();
        test_lock_drop();
        test_starve_lock();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/octree_sram_arbiter.md
Name: octree_sram_arbiter

Overview:
- Cycle-level arbiter sharing the single-port octree node SRAM between the searcher (traversal reads) and the updater (anchor add/delete read-modify-write).
- Replaces whole-operation muxing with per-access arbitration, so search and update traffic can interleave.
- Searcher has latency priority. The updater is protected by a starvation guard and can lock the port across an RMW sequence.

Parameters:
- ADDR_W, 10, SRAM word address width.
- DATA_W, 64, SRAM word width.
- MAX_WAIT, 4, consecutive cycles the updater may be denied while requesting before it is forced a grant; range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_req  in  1  searcher access request
- s_we  in  1  searcher write enable (1 = write)
- s_addr  in  ADDR_W  searcher address
- s_wdata  in  DATA_W  searcher write data
- s_lock  in  1  searcher requests port lock, sampled on a granted cycle
- s_gnt  out  1  searcher access accepted this cycle
- s_rvalid  out  1  searcher read data valid
- u_req, u_we, u_addr, u_wdata, u_lock, u_gnt, u_rvalid  same as s_* for the updater
- rdata  out  DATA_W  read data, shared by both requesters (mem_rdata passthrough)
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after a read cs
- mem_owner  out  2  registered grantee of the previous cycle: 0 = none, 1 = searcher, 2 = updater
- starve_flag  out  1  high while the starvation counter is saturated

Behaviour:
- Reset:
  - All registered state clears: lock_owner = none, starve_cnt = 0, s_rvalid = u_rvalid = 0, mem_owner = 0.
  - Combinational outputs follow from cleared state: gnt = 0 and mem_cs = 0 when no req.
- Grant decision (combinational, same cycle as req), evaluated in this order:
  1. Lock held by X: only X may be granted; X granted iff X_req. The other requester is denied.
  2. No lock, updater forced (starve_cnt == MAX_WAIT) and u_req: grant updater.
  3. No lock, s_req: grant searcher.
  4. No lock, u_req: grant updater.
  5. Otherwise no grant.
- Memory command: on a grant, mem_cs = 1 and mem_we/addr/wdata come from the grantee. With no grant, mem_cs = 0, mem_we = 0, addr/wdata = 0.
- Read return:
  - X_rvalid registers (X_gnt & ~X_we); it is high exactly 1 cycle after the granted read.
  - rdata = mem_rdata, combinational.
  - A granted write produces no rvalid.
- Lock state (register lock_owner ∈ {none, S, U}):
  - none -> X when X is granted with X_lock = 1.
  - X -> none when X is granted with X_lock = 0 (that access completes as the final locked access), or when X_req = 0 in any cycle.
  - While locked, the lock persists across consecutive granted cycles with X_lock = 1.
  - The lock overrides the starvation guard.
- Starvation counter (starve_cnt, 4-bit, saturating at MAX_WAIT):
  - Increments when u_req & ~u_gnt.
  - Clears when u_gnt or ~u_req.
  - Holds MAX_WAIT while a searcher lock blocks the updater; the updater is granted on the first unlocked cycle.
  - starve_flag = (starve_cnt == MAX_WAIT).
- mem_owner: registered encoding of this cycle's grantee; updates every cycle.
- Simultaneous events:
  - Both req, no lock, no starvation: searcher granted.
  - A lock release and the other requester's req in the same cycle: the other requester is granted the next cycle, not the release cycle.
- Requester contract:
  - Hold req, we, addr, wdata and lock stable until gnt.
  - A read in flight completes regardless of later arbitration.
- Reset mid-operation: an in-flight read's rvalid is dropped; requesters re-issue after reset.

Test Plan:
1. Searcher only: s_req = 1 reads addr 0x010..0x013 back-to-back -> s_gnt = 1 each cycle; s_rvalid 1 cycle later with rdata = SRAM contents; mem_owner = 1 lagging grants by 1 cycle.
2. Contention, MAX_WAIT = 4: s_req and u_req held high continuously -> grant pattern S,S,S,S,U repeating; starve_flag high in the cycle of each U grant; u_gnt after exactly 4 denied cycles.
3. Updater RMW lock: u_req with u_lock = 1 reads 0x020, then writes 0x020 = 0xDEAD with u_lock = 0, while s_req = 1 throughout -> both accesses granted to updater consecutively, s_gnt = 0 during them, searcher granted the cycle after the write; SRAM[0x020] = 0xDEAD.
4. Lock released by req drop: searcher locks on a read of 0x030, then s_req = 0 -> lock_owner returns to none; pending u_req granted the next cycle.
5. Searcher lock vs starved updater: starve_cnt = 4 while searcher holds lock for 6 cycles -> u_gnt = 0 throughout; u_gnt = 1 on the first cycle after release, even with s_req = 1.
6. Reset mid-read: assert rst_n = 0 the cycle after a granted u read -> u_rvalid = 0, mem_owner = 0, lock and starve_cnt cleared; the first post-reset contended cycle grants the searcher.
